// File: rtl/rv_ctrl_pkg.sv
// Shared constants and types for the RV32I pipeline controller.
//   - RV32I major opcodes the hazard logic cares about
//   - canonical NOP (addi x0, x0, 0) loaded into flushed stage registers
//   - controller state enum
//   - operand forwarding select encodings
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_ME = 2'b10;

endpackage

// File: rtl/rv_operand_decode.sv
// Combinational register-field decode of one RV32I instruction word.
// Ports:
//   ir_i        instruction word held in a stage register
//   rs1_o/rs2_o source register indices
//   rd_o        destination register index
//   uses_rs1_o  instruction reads rs1
//   uses_rs2_o  instruction reads rs2
//   writes_rd_o instruction writes a non-zero rd
//   is_load_o   LOAD opcode
//   is_mem_o    LOAD or STORE opcode
module rv_operand_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o,
    output logic        writes_rd_o,
    output logic        is_load_o,
    output logic        is_mem_o
);

    logic [6:0] opc;
    // funct3/funct7 never influence hazards; tie them off explicitly.
    logic       unused_funct;

    assign opc          = ir_i[6:0];
    assign unused_funct = ^{ir_i[31:25], ir_i[14:12]};

    assign rd_o  = ir_i[11:7];
    assign rs1_o = ir_i[19:15];
    assign rs2_o = ir_i[24:20];

    assign uses_rs1_o  = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    assign uses_rs2_o  = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    // x0 writes are architecturally discarded, so they never create a hazard.
    assign writes_rd_o = !((opc == OPC_STORE) || (opc == OPC_BRANCH)) && (ir_i[11:7] != 5'd0);
    assign is_load_o   = (opc == OPC_LOAD);
    assign is_mem_o    = (opc == OPC_LOAD) || (opc == OPC_STORE);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage RV32I pipeline controller: stage enables, flushes, load-use
// bubbles, operand forwarding, per-stage valid tracking, data-memory wait
// sequencing with timeout fault, and saturating stall/flush counters.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_RUN      | normal flow; branch, load-use and mem-hold evaluated
//   ST_MEM_WAIT | memory stage waiting on mem_rdy; whole pipe frozen
//   ST_FAULT    | memory timed out; pipe frozen until rst
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ir_dc, ir_ex, ir_me      IR held in decode / execute / memory registers
//   cp_ex                    branch or jump taken, resolved in execute
//   mem_rdy                  data memory completes its access this cycle
//   en_fe..en_wb             stage-register load enables
//   flush_dc, flush_ex       load NOP into decode / execute registers
//   fwd_a, fwd_b             rs1 / rs2 operand source select for execute
//   mem_en, wb_en            memory / writeback side effects permitted
//   fault                    sticky memory timeout
//   stall_cnt, flush_cnt     saturating performance counters
module pipe_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ir_dc,
    input  logic [31:0]      ir_ex,
    input  logic [31:0]      ir_me,
    input  logic             cp_ex,
    input  logic             mem_rdy,
    output logic             en_fe,
    output logic             en_dc,
    output logic             en_ex,
    output logic             en_me,
    output logic             en_wb,
    output logic             flush_dc,
    output logic             flush_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_en,
    output logic             wb_en,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [4:0] rs1_dc, rs2_dc, rd_dc, rs1_ex, rs2_ex, rd_ex, rs1_me, rs2_me, rd_me;
    logic       use1_dc, use2_dc, wr_dc, ld_dc, mem_dc;
    logic       use1_ex, use2_ex, wr_ex, ld_ex, mem_ex;
    logic       use1_me, use2_me, wr_me, ld_me, mem_me;
    logic       unused_dec;

    rv_operand_decode u_dec_dc (
        .ir_i(ir_dc), .rs1_o(rs1_dc), .rs2_o(rs2_dc), .rd_o(rd_dc),
        .uses_rs1_o(use1_dc), .uses_rs2_o(use2_dc), .writes_rd_o(wr_dc),
        .is_load_o(ld_dc), .is_mem_o(mem_dc)
    );
    rv_operand_decode u_dec_ex (
        .ir_i(ir_ex), .rs1_o(rs1_ex), .rs2_o(rs2_ex), .rd_o(rd_ex),
        .uses_rs1_o(use1_ex), .uses_rs2_o(use2_ex), .writes_rd_o(wr_ex),
        .is_load_o(ld_ex), .is_mem_o(mem_ex)
    );
    rv_operand_decode u_dec_me (
        .ir_i(ir_me), .rs1_o(rs1_me), .rs2_o(rs2_me), .rd_o(rd_me),
        .uses_rs1_o(use1_me), .uses_rs2_o(use2_me), .writes_rd_o(wr_me),
        .is_load_o(ld_me), .is_mem_o(mem_me)
    );

    // Each stage only needs part of the decode.
    assign unused_dec = ^{rd_dc, wr_dc, ld_dc, mem_dc, rs1_ex, rs2_ex, use1_ex, use2_ex,
                          mem_ex, rs1_me, rs2_me, use1_me, use2_me, ld_me};

    state_e            state_q;
    logic              valid_dc_q, valid_ex_q, valid_me_q, valid_wb_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;

    logic mem_hold, branch, ld_use;

    assign mem_hold = valid_me_q & mem_me & ~mem_rdy;
    assign branch   = cp_ex & valid_ex_q;
    assign ld_use   = valid_ex_q & ld_ex & wr_ex &
                      ((use1_dc & (rd_ex == rs1_dc)) | (use2_dc & (rd_ex == rs2_dc)));

    // RUN and MEM_WAIT share the same priority chain: inside MEM_WAIT the
    // hold term is true exactly while mem_rdy is low, and on the release
    // cycle branch and load-use are evaluated as in RUN.
    always_comb begin
        en_fe    = 1'b0;
        en_dc    = 1'b0;
        en_ex    = 1'b0;
        en_me    = 1'b0;
        en_wb    = 1'b0;
        flush_dc = 1'b0;
        flush_ex = 1'b0;
        if (!rst && (state_q == ST_RUN || state_q == ST_MEM_WAIT)) begin
            if (mem_hold) begin
                en_fe = 1'b0;
            end else if (branch) begin
                {en_fe, en_dc, en_ex, en_me, en_wb} = 5'b11111;
                flush_dc = 1'b1;
                flush_ex = 1'b1;
            end else if (ld_use) begin
                // Hold fetch/decode, let execute take a NOP bubble.
                {en_ex, en_me, en_wb} = 3'b111;
                flush_ex = 1'b1;
            end else begin
                {en_fe, en_dc, en_ex, en_me, en_wb} = 5'b11111;
            end
        end
    end

    // Loads are never forwarded from execute; load-use stalls cover them.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!rst) begin
            if (valid_ex_q && wr_ex && !ld_ex && (rd_ex == rs1_dc))  fwd_a = FWD_EX;
            else if (valid_me_q && wr_me && (rd_me == rs1_dc))       fwd_a = FWD_ME;
            if (valid_ex_q && wr_ex && !ld_ex && (rd_ex == rs2_dc))  fwd_b = FWD_EX;
            else if (valid_me_q && wr_me && (rd_me == rs2_dc))       fwd_b = FWD_ME;
        end
    end

    assign mem_en    = valid_me_q & ~rst;
    assign wb_en     = valid_wb_q & ~rst;
    assign fault     = (state_q == ST_FAULT) & ~rst;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

    assign stall_d = (&stall_q) ? stall_q : stall_q + CNT_W'(1);
    assign flush_d = (&flush_q) ? flush_q : flush_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            valid_dc_q <= 1'b0;
            valid_ex_q <= 1'b0;
            valid_me_q <= 1'b0;
            valid_wb_q <= 1'b0;
            wait_q     <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            // wait_q counts low-mem_rdy cycles already spent, so the fault
            // fires at the end of the MAX_WAIT-th consecutive wait cycle.
            case (state_q)
                ST_RUN: begin
                    if (mem_hold) begin
                        state_q <= (MAX_WAIT <= 1) ? ST_FAULT : ST_MEM_WAIT;
                        wait_q  <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_rdy) begin
                        state_q <= ST_RUN;
                        wait_q  <= '0;
                    end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                        state_q <= ST_FAULT;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_FAULT: state_q <= ST_FAULT;
                default:  state_q <= ST_RUN;
            endcase

            // The fetch stage always supplies a real instruction after reset.
            if (flush_dc)   valid_dc_q <= 1'b0;
            else if (en_dc) valid_dc_q <= 1'b1;
            if (flush_ex)   valid_ex_q <= 1'b0;
            else if (en_ex) valid_ex_q <= en_dc & valid_dc_q;
            if (en_me)      valid_me_q <= valid_ex_q;
            if (en_wb)      valid_wb_q <= valid_me_q;

            if (!en_fe && state_q != ST_FAULT) stall_q <= stall_d;
            if (flush_dc)                      flush_q <= flush_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    import rv_ctrl_pkg::*;

    localparam logic [31:0] ADDI_X1_X1 = 32'h00108093;
    localparam logic [31:0] ADDI_X5_X0 = 32'h00100293;
    localparam logic [31:0] ADD_X3     = 32'h002081B3;
    localparam logic [31:0] ADD_X0     = 32'h00208033;
    localparam logic [31:0] SUB_X4_X3  = 32'h40318233;
    localparam logic [31:0] SUB_X4_X0  = 32'h40000233;
    localparam logic [31:0] ADD_X7_3_5 = 32'h005183B3;
    localparam logic [31:0] LW_X5      = 32'h0000A283;
    localparam logic [31:0] ADD_X6_5_2 = 32'h00228333;
    localparam logic [31:0] SW_X2      = 32'h0020A023;
    localparam logic [31:0] BEQ        = 32'h00000063;

    logic        clk;
    logic        rst;
    logic [31:0] ir_dc, ir_ex, ir_me;
    logic        cp_ex, mem_rdy;
    logic        en_fe, en_dc, en_ex, en_me, en_wb;
    logic        flush_dc, flush_ex;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_en, wb_en, fault;
    logic [31:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_ctrl #(.CNT_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .ir_dc(ir_dc), .ir_ex(ir_ex), .ir_me(ir_me),
        .cp_ex(cp_ex), .mem_rdy(mem_rdy),
        .en_fe(en_fe), .en_dc(en_dc), .en_ex(en_ex), .en_me(en_me), .en_wb(en_wb),
        .flush_dc(flush_dc), .flush_ex(flush_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_en(mem_en), .wb_en(wb_en), .fault(fault),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: time %0t reached, required finish before 50000", $time);
        $fatal(1);
    end

    task automatic set_in(input logic [31:0] dc, input logic [31:0] ex, input logic [31:0] me,
                          input logic cp, input logic rdy);
        ir_dc   = dc;
        ir_ex   = ex;
        ir_me   = me;
        cp_ex   = cp;
        mem_rdy = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_wb, exp_me;
        rst = 1'b1;
        set_in(ADDI_X1_X1, ADDI_X1_X1, ADDI_X1_X1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({en_fe, en_dc, en_ex, en_me, en_wb} !== 5'b00000) begin
                n_bad++; $display("FAIL reset_en[%0d]: got %b want 00000", i, {en_fe, en_dc, en_ex, en_me, en_wb});
            end
            n_cmp++;
            if ({flush_dc, flush_ex, fwd_a, fwd_b} !== 6'b0) begin
                n_bad++; $display("FAIL reset_flush_fwd[%0d]: got %b want 000000", i, {flush_dc, flush_ex, fwd_a, fwd_b});
            end
            n_cmp++;
            if ({mem_en, wb_en, fault} !== 3'b000) begin
                n_bad++; $display("FAIL reset_memwb_fault[%0d]: got %b want 000", i, {mem_en, wb_en, fault});
            end
            step();
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_wb = (i >= 4);
            exp_me = (i >= 3);
            @(negedge clk);
            n_cmp++;
            if (wb_en !== exp_wb) begin
                n_bad++; $display("FAIL fill_wb_en[%0d]: got %b want %b", i, wb_en, exp_wb);
            end
            n_cmp++;
            if (mem_en !== exp_me) begin
                n_bad++; $display("FAIL fill_mem_en[%0d]: got %b want %b", i, mem_en, exp_me);
            end
            n_cmp++;
            if ({en_fe, en_dc, en_ex, en_me, en_wb} !== 5'b11111) begin
                n_bad++; $display("FAIL fill_en[%0d]: got %b want 11111", i, {en_fe, en_dc, en_ex, en_me, en_wb});
            end
            step();
        end
        @(negedge clk);
        n_cmp++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_bad++; $display("FAIL fill_counters: got stall %0d flush %0d want 0 0", stall_cnt, flush_cnt);
        end
        step();
    endtask

    task automatic test_alu_fwd();
        logic [31:0] v_dc [5];
        logic [31:0] v_ex [5];
        logic [31:0] v_me [5];
        logic [1:0]  exp_a [5];
        logic [1:0]  exp_b [5];
        v_dc  = '{SUB_X4_X3, SUB_X4_X0, SUB_X4_X3, ADD_X7_3_5, SUB_X4_X3};
        v_ex  = '{ADD_X3,    ADD_X0,    ADD_X3,    ADDI_X5_X0, NOP_INSN};
        v_me  = '{NOP_INSN,  NOP_INSN,  ADD_X3,    ADD_X3,     ADD_X3};
        exp_a = '{2'b01,     2'b00,     2'b01,     2'b10,      2'b10};
        exp_b = '{2'b01,     2'b00,     2'b01,     2'b01,      2'b10};
        for (int i = 0; i < 5; i++) begin
            set_in(v_dc[i], v_ex[i], v_me[i], 1'b0, 1'b1);
            @(negedge clk);
            n_cmp++;
            if (fwd_a !== exp_a[i]) begin
                n_bad++; $display("FAIL alu_fwd_a[%0d]: got %b want %b", i, fwd_a, exp_a[i]);
            end
            n_cmp++;
            if (fwd_b !== exp_b[i]) begin
                n_bad++; $display("FAIL alu_fwd_b[%0d]: got %b want %b", i, fwd_b, exp_b[i]);
            end
            n_cmp++;
            if ({en_fe, en_dc, flush_ex} !== 3'b110) begin
                n_bad++; $display("FAIL alu_no_stall[%0d]: got %b want 110", i, {en_fe, en_dc, flush_ex});
            end
            step();
        end
    endtask

    task automatic test_load_use();
        set_in(ADD_X6_5_2, LW_X5, NOP_INSN, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({en_fe, en_dc, en_ex, en_me, en_wb} !== 5'b00111) begin
            n_bad++; $display("FAIL lu_en: got %b want 00111", {en_fe, en_dc, en_ex, en_me, en_wb});
        end
        n_cmp++;
        if ({flush_dc, flush_ex} !== 2'b01) begin
            n_bad++; $display("FAIL lu_flush: got %b want 01", {flush_dc, flush_ex});
        end
        n_cmp++;
        if (fwd_a !== 2'b00) begin
            n_bad++; $display("FAIL lu_no_ex_fwd: got %b want 00", fwd_a);
        end
        step();
        set_in(ADD_X6_5_2, NOP_INSN, LW_X5, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            n_bad++; $display("FAIL lu_fwd: got a=%b b=%b want a=10 b=00", fwd_a, fwd_b);
        end
        n_cmp++;
        if ({en_fe, en_dc, en_ex, en_me, en_wb, flush_ex} !== 6'b111110) begin
            n_bad++; $display("FAIL lu_resume: got %b want 111110", {en_fe, en_dc, en_ex, en_me, en_wb, flush_ex});
        end
        n_cmp++;
        if (stall_cnt !== 32'd1) begin
            n_bad++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt);
        end
        step();
    endtask

    task automatic test_branch();
        logic exp_me [3];
        exp_me = '{1'b0, 1'b0, 1'b1};
        set_in(NOP_INSN, BEQ, NOP_INSN, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({flush_dc, flush_ex} !== 2'b11) begin
            n_bad++; $display("FAIL br_flush: got %b want 11", {flush_dc, flush_ex});
        end
        n_cmp++;
        if ({en_fe, en_dc, en_ex, en_me, en_wb} !== 5'b11111) begin
            n_bad++; $display("FAIL br_en: got %b want 11111", {en_fe, en_dc, en_ex, en_me, en_wb});
        end
        step();
        // cp_ex still high but execute now holds a flushed, invalid slot.
        set_in(NOP_INSN, NOP_INSN, BEQ, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({flush_dc, flush_ex} !== 2'b00) begin
            n_bad++; $display("FAIL br_invalid_ex: got %b want 00", {flush_dc, flush_ex});
        end
        n_cmp++;
        if (flush_cnt !== 32'd1) begin
            n_bad++; $display("FAIL br_flush_cnt: got %0d want 1", flush_cnt);
        end
        n_cmp++;
        if (mem_en !== 1'b1) begin
            n_bad++; $display("FAIL br_mem_en_0: got %b want 1", mem_en);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(NOP_INSN, NOP_INSN, NOP_INSN, 1'b0, 1'b1);
            @(negedge clk);
            n_cmp++;
            if (mem_en !== exp_me[i]) begin
                n_bad++; $display("FAIL br_bubble_mem_en[%0d]: got %b want %b", i, mem_en, exp_me[i]);
            end
            if (i == 1) begin
                n_cmp++;
                if (wb_en !== 1'b0) begin
                    n_bad++; $display("FAIL br_bubble_wb_en: got %b want 0", wb_en);
                end
            end
            step();
        end
    endtask

    task automatic test_mem_wait();
        // A taken branch sits in execute throughout; the hold must win.
        for (int i = 0; i < 3; i++) begin
            set_in(NOP_INSN, BEQ, SW_X2, 1'b1, 1'b0);
            @(negedge clk);
            n_cmp++;
            if ({en_fe, en_dc, en_ex, en_me, en_wb, flush_dc, flush_ex} !== 7'b0) begin
                n_bad++; $display("FAIL mw_hold[%0d]: got %b want 0000000", i,
                                  {en_fe, en_dc, en_ex, en_me, en_wb, flush_dc, flush_ex});
            end
            n_cmp++;
            if (fault !== 1'b0 || mem_en !== 1'b1) begin
                n_bad++; $display("FAIL mw_fault_memen[%0d]: got fault %b mem_en %b want 0 1", i, fault, mem_en);
            end
            step();
        end
        set_in(NOP_INSN, BEQ, SW_X2, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({en_fe, en_dc, en_ex, en_me, en_wb, flush_dc, flush_ex} !== 7'b1111111) begin
            n_bad++; $display("FAIL mw_release_branch: got %b want 1111111",
                              {en_fe, en_dc, en_ex, en_me, en_wb, flush_dc, flush_ex});
        end
        n_cmp++;
        if (stall_cnt !== 32'd4) begin
            n_bad++; $display("FAIL mw_stall_cnt: got %0d want 4", stall_cnt);
        end
        step();
        set_in(NOP_INSN, NOP_INSN, BEQ, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (flush_cnt !== 32'd2 || fault !== 1'b0) begin
            n_bad++; $display("FAIL mw_after: got flush_cnt %0d fault %b want 2 0", flush_cnt, fault);
        end
        step();
    endtask

    task automatic test_timeout();
        logic rdy;
        for (int i = 0; i < 3; i++) begin
            set_in(NOP_INSN, NOP_INSN, NOP_INSN, 1'b0, 1'b1);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            set_in(NOP_INSN, NOP_INSN, SW_X2, 1'b0, 1'b0);
            @(negedge clk);
            n_cmp++;
            if ({en_fe, en_wb, fault} !== 3'b000) begin
                n_bad++; $display("FAIL to_wait[%0d]: got en_fe,en_wb,fault %b want 000", i, {en_fe, en_wb, fault});
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            rdy = (i >= 1);
            set_in(NOP_INSN, NOP_INSN, SW_X2, 1'b0, rdy);
            @(negedge clk);
            n_cmp++;
            if ({fault, en_fe, en_wb} !== 3'b100) begin
                n_bad++; $display("FAIL to_fault[%0d]: got fault,en_fe,en_wb %b want 100", i, {fault, en_fe, en_wb});
            end
            step();
        end
        @(negedge clk);
        n_cmp++;
        if (stall_cnt !== 32'd8) begin
            n_bad++; $display("FAIL to_stall_cnt: got %0d want 8", stall_cnt);
        end
        step();
        rst = 1'b1;
        set_in(NOP_INSN, NOP_INSN, NOP_INSN, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({fault, en_fe, mem_en} !== 3'b000) begin
            n_bad++; $display("FAIL to_in_reset: got fault,en_fe,mem_en %b want 000", {fault, en_fe, mem_en});
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({fault, en_fe, en_wb, wb_en} !== 4'b0110) begin
            n_bad++; $display("FAIL to_after_reset: got fault,en_fe,en_wb,wb_en %b want 0110", {fault, en_fe, en_wb, wb_en});
        end
        n_cmp++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_bad++; $display("FAIL to_counters_cleared: got stall %0d flush %0d want 0 0", stall_cnt, flush_cnt);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        set_in(NOP_INSN, NOP_INSN, NOP_INSN, 1'b0, 1'b1);
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
